// File: rtl/dlx_dm_responder.sv
// dlx_dm_responder: MEM-stage data-memory responder for the DLX core.
// Word-addressed data RAM with byte-lane writes, plus a write-only VGA region
// whose 32-bit words are serialised into a 1-bit framebuffer one pixel per
// cycle while the core is stalled.
// Optional build macro DM_TRACE_EN adds a per-request trace port set.
module dlx_dm_responder #(
  parameter int DEPTH_WORDS = 4096,
  parameter int FB_WORDS    = 600,
  parameter int ADDR_W      = 15
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              DM_read,
  input  logic              DM_write,
  input  logic [ADDR_W-1:0] DM_addr_eff,
  input  logic [3:0]        mask,
  input  logic [31:0]       DM_write_data,
  output logic [31:0]       DM_read_data,
  output logic              stall,
  output logic              fb_we,
  output logic [14:0]       fb_addr,
  output logic              fb_pix,
  output logic              fb_err
`ifdef DM_TRACE_EN
  ,
  output logic              trace_valid,
  output logic              trace_rw,
  output logic [ADDR_W-1:0] trace_addr,
  output logic [31:0]       trace_data,
  output logic [15:0]       trace_count
`endif
);

  localparam int RAM_AW = $clog2(DEPTH_WORDS);
  localparam int W_W    = ADDR_W - 1;
  localparam int FB_AW  = 15;

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t            state;
  logic [4:0]        k;
  logic [4:0]        k_nxt;
  logic [31:0]       data_lat;
  logic [3:0]        mask_lat;
  logic [31:0]       mem [DEPTH_WORDS];

  logic              accept;
  logic              is_vga;
  logic              vga_ok;
  logic              vga_drop;
  logic              ram_wr;
  logic              rd_acc;
  logic [W_W-1:0]    w;
  logic [RAM_AW-1:0] ram_idx;

  // Request decode: only IDLE accepts; write wins when read and write are both set.
  assign w        = DM_addr_eff[W_W-1:0];
  assign ram_idx  = DM_addr_eff[RAM_AW-1:0];
  assign is_vga   = DM_addr_eff[ADDR_W-1];
  assign accept   = (state == IDLE) && (DM_read || DM_write);
  assign vga_ok   = accept && DM_write && is_vga && (w <  W_W'(FB_WORDS));
  assign vga_drop = accept && DM_write && is_vga && (w >= W_W'(FB_WORDS));
  assign ram_wr   = accept && DM_write && !is_vga;
  assign rd_acc   = accept && !DM_write;
  assign k_nxt    = k + 5'd1;

  // Stall covers the accept cycle and every SHIFT pixel but the last; the
  // reset gate keeps it low while reset is asserted even if a write is held.
  assign stall = reset && (vga_ok || ((state == SHIFT) && !(&k)));

  // Serialiser FSM and registered framebuffer outputs, aligned with k.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      k       <= 5'd0;
      fb_we   <= 1'b0;
      fb_addr <= '0;
      fb_pix  <= 1'b0;
      fb_err  <= 1'b0;
    end else begin
      fb_err <= vga_drop;
      if (state == IDLE) begin
        if (vga_ok) begin
          state   <= SHIFT;
          k       <= 5'd0;
          fb_we   <= mask[0];
          fb_addr <= FB_AW'({w, 5'd0});
          fb_pix  <= DM_write_data[0];
        end else begin
          fb_we <= 1'b0;
        end
      end else begin
        if (&k) begin
          state <= IDLE;
          fb_we <= 1'b0;
        end else begin
          k       <= k_nxt;
          fb_we   <= mask_lat[k_nxt[4:3]];
          fb_addr <= fb_addr + 15'd1;
          fb_pix  <= data_lat[k_nxt];
        end
      end
    end
  end

  // Latch the VGA word and its lane mask at accept for the SHIFT sequence.
  always_ff @(posedge clk) begin
    if (vga_ok) begin
      data_lat <= DM_write_data;
      mask_lat <= mask;
    end
  end

  // Data RAM byte-lane write, completing on the accept edge.
  always_ff @(posedge clk) begin
    if (ram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) mem[ram_idx][8*i +: 8] <= DM_write_data[8*i +: 8];
      end
    end
  end

  // Read data register: RAM word or zero for the VGA region; holds otherwise.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      DM_read_data <= '0;
    end else if (rd_acc) begin
      DM_read_data <= is_vga ? 32'd0 : mem[ram_idx];
    end
  end

`ifdef DM_TRACE_EN
  // One trace record per accepted request, with a saturating accept counter.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      trace_valid <= 1'b0;
      trace_rw    <= 1'b0;
      trace_addr  <= '0;
      trace_data  <= '0;
      trace_count <= '0;
    end else begin
      trace_valid <= accept;
      if (accept) begin
        trace_rw   <= DM_write;
        trace_addr <= DM_addr_eff;
        if (DM_write)    trace_data <= DM_write_data;
        else if (is_vga) trace_data <= 32'd0;
        else             trace_data <= mem[ram_idx];
        if (trace_count != 16'hFFFF) trace_count <= trace_count + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dlx_dm_responder.sv
// Directed bench for dlx_dm_responder: RAM read/write, byte masks, VGA
// serialisation, out-of-range VGA drop, reset abort and read+write priority.
module tb_dlx_dm_responder;

  logic        clk;
  logic        reset;
  logic        DM_read;
  logic        DM_write;
  logic [14:0] DM_addr_eff;
  logic [3:0]  mask;
  logic [31:0] DM_write_data;
  logic [31:0] DM_read_data;
  logic        stall;
  logic        fb_we;
  logic [14:0] fb_addr;
  logic        fb_pix;
  logic        fb_err;
`ifdef DM_TRACE_EN
  logic        trace_valid;
  logic        trace_rw;
  logic [14:0] trace_addr;
  logic [31:0] trace_data;
  logic [15:0] trace_count;
`endif

  int errors = 0;
  int checks = 0;

  dlx_dm_responder dut (
    .clk(clk),
    .reset(reset),
    .DM_read(DM_read),
    .DM_write(DM_write),
    .DM_addr_eff(DM_addr_eff),
    .mask(mask),
    .DM_write_data(DM_write_data),
    .DM_read_data(DM_read_data),
    .stall(stall),
    .fb_we(fb_we),
    .fb_addr(fb_addr),
    .fb_pix(fb_pix),
    .fb_err(fb_err)
`ifdef DM_TRACE_EN
    ,
    .trace_valid(trace_valid),
    .trace_rw(trace_rw),
    .trace_addr(trace_addr),
    .trace_data(trace_data),
    .trace_count(trace_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_bus();
    DM_read = 1'b0;
    DM_write = 1'b0;
    DM_addr_eff = '0;
    mask = 4'h0;
    DM_write_data = '0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    idle_bus();
    #100;
    checks++; if (DM_read_data !== 32'd0) begin errors++; $display("FAIL reset_rdata got=%h exp=0", DM_read_data); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL reset_fb_we got=%b exp=0", fb_we); end
    checks++; if (fb_addr !== 15'd0) begin errors++; $display("FAIL reset_fb_addr got=%0d exp=0", fb_addr); end
    checks++; if (fb_pix !== 1'b0) begin errors++; $display("FAIL reset_fb_pix got=%b exp=0", fb_pix); end
    checks++; if (fb_err !== 1'b0) begin errors++; $display("FAIL reset_fb_err got=%b exp=0", fb_err); end
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_ram_rw();
    DM_write = 1'b1; DM_addr_eff = 15'h0010; mask = 4'hF; DM_write_data = 32'hDEADBEEF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ram_wr_stall got=%b exp=0", stall); end
    cyc();
    DM_write = 1'b0; DM_read = 1'b1; DM_addr_eff = 15'h0010;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL ram_rd_stall got=%b exp=0", stall); end
    cyc();
    idle_bus();
    checks++; if (DM_read_data !== 32'hDEADBEEF) begin errors++; $display("FAIL ram_rd_data got=%h exp=DEADBEEF", DM_read_data); end
    cyc();
  endtask

  task automatic test_byte_mask();
    DM_write = 1'b1; DM_addr_eff = 15'h0010; mask = 4'b0010; DM_write_data = 32'h11223344;
    cyc();
    DM_write = 1'b0; DM_read = 1'b1; DM_addr_eff = 15'h0010; mask = 4'h0;
    cyc();
    idle_bus();
    checks++; if (DM_read_data !== 32'hDEAD33EF) begin errors++; $display("FAIL mask_rd_data got=%h exp=DEAD33EF", DM_read_data); end
    cyc();
  endtask

  task automatic test_vga_write();
    int stall_cnt;
    logic exp_pix;
    stall_cnt = 0;
    DM_write = 1'b1; DM_addr_eff = 15'h4001; mask = 4'hF; DM_write_data = 32'h80000001;
    #1;
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL vga_accept_stall got=%b exp=1", stall); end
    cyc();
    for (int k = 0; k < 32; k++) begin
      exp_pix = (k == 0) || (k == 31);
      checks++; if (fb_we !== 1'b1) begin errors++; $display("FAIL vga_we k=%0d got=%b exp=1", k, fb_we); end
      checks++; if (fb_addr !== 15'(32 + k)) begin errors++; $display("FAIL vga_addr k=%0d got=%0d exp=%0d", k, fb_addr, 32 + k); end
      checks++; if (fb_pix !== exp_pix) begin errors++; $display("FAIL vga_pix k=%0d got=%b exp=%b", k, fb_pix, exp_pix); end
      if (stall === 1'b1) stall_cnt++;
      if (k == 31) begin
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL vga_last_stall got=%b exp=0", stall); end
        idle_bus();
      end
      cyc();
    end
    checks++; if (stall_cnt != 31) begin errors++; $display("FAIL vga_stall_count got=%0d exp=31", stall_cnt); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL vga_done_we got=%b exp=0", fb_we); end
    checks++; if (fb_addr !== 15'd63) begin errors++; $display("FAIL vga_hold_addr got=%0d exp=63", fb_addr); end
    cyc();
  endtask

  task automatic test_vga_out_of_range();
    DM_write = 1'b1; DM_addr_eff = 15'h4000 + 15'd600; mask = 4'hF; DM_write_data = 32'hFFFFFFFF;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL oor_stall got=%b exp=0", stall); end
    cyc();
    idle_bus();
    checks++; if (fb_err !== 1'b1) begin errors++; $display("FAIL oor_err_pulse got=%b exp=1", fb_err); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL oor_we got=%b exp=0", fb_we); end
    cyc();
    checks++; if (fb_err !== 1'b0) begin errors++; $display("FAIL oor_err_clear got=%b exp=0", fb_err); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL oor_we_after got=%b exp=0", fb_we); end
  endtask

  task automatic test_vga_read();
    DM_read = 1'b1; DM_addr_eff = 15'h4001;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL vga_rd_stall got=%b exp=0", stall); end
    cyc();
    idle_bus();
    checks++; if (DM_read_data !== 32'd0) begin errors++; $display("FAIL vga_rd_data got=%h exp=0", DM_read_data); end
    cyc();
  endtask

  task automatic test_reset_abort();
    logic exp_we;
    DM_write = 1'b1; DM_addr_eff = 15'h4002; mask = 4'b0101; DM_write_data = 32'hFFFFFFFF;
    cyc();
    for (int k = 0; k < 10; k++) begin
      exp_we = (k < 8);
      checks++; if (fb_we !== exp_we) begin errors++; $display("FAIL abort_we k=%0d got=%b exp=%b", k, fb_we, exp_we); end
      cyc();
    end
    #2;
    reset = 1'b0;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL abort_stall got=%b exp=0", stall); end
    checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL abort_we_now got=%b exp=0", fb_we); end
    cyc();
    idle_bus();
    @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (fb_we !== 1'b0) begin errors++; $display("FAIL abort_we_after i=%0d got=%b exp=0", i, fb_we); end
    end
    DM_read = 1'b1; DM_addr_eff = 15'h0010;
    cyc();
    idle_bus();
    checks++; if (DM_read_data !== 32'hDEAD33EF) begin errors++; $display("FAIL abort_rd_data got=%h exp=DEAD33EF", DM_read_data); end
    cyc();
  endtask

  task automatic test_read_write_both();
`ifdef DM_TRACE_EN
    logic [15:0] cnt0;
    cnt0 = trace_count;
`endif
    DM_read = 1'b1; DM_write = 1'b1; DM_addr_eff = 15'h0020; mask = 4'hF; DM_write_data = 32'h5A5A5A5A;
    #1;
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL both_stall got=%b exp=0", stall); end
    cyc();
    idle_bus();
    checks++; if (DM_read_data !== 32'hDEAD33EF) begin errors++; $display("FAIL both_rdata_hold got=%h exp=DEAD33EF", DM_read_data); end
`ifdef DM_TRACE_EN
    checks++; if (trace_valid !== 1'b1) begin errors++; $display("FAIL both_trace_valid got=%b exp=1", trace_valid); end
    checks++; if (trace_rw !== 1'b1) begin errors++; $display("FAIL both_trace_rw got=%b exp=1", trace_rw); end
    checks++; if (trace_count !== cnt0 + 16'd1) begin errors++; $display("FAIL both_trace_count got=%0d exp=%0d", trace_count, cnt0 + 16'd1); end
`endif
    DM_read = 1'b1; DM_addr_eff = 15'h0020;
    cyc();
    idle_bus();
    checks++; if (DM_read_data !== 32'h5A5A5A5A) begin errors++; $display("FAIL both_ram_updated got=%h exp=5A5A5A5A", DM_read_data); end
    cyc();
  endtask

  initial begin
    test_reset();
    test_ram_rw();
    test_byte_mask();
    test_vga_write();
    test_vga_out_of_range();
    test_vga_read();
    test_reset_abort();
    test_read_write_both();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
